tqvp_uart_rx_fifo: RTL

Parametrised UART receiver for TinyQV peripherals. Supports runtime-selectable frame format: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits. Adds input synchronisation, false-start rejection, parity/framing/break detection and an RX FIFO with overrun flag. RTS flow control is driven from FIFO fill level. It sits between the `uart_rxd` pin and the peripheral register interface.

---
 rtl/tqvp_uart_rx_fifo.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/tqvp_uart_rx_fifo.sv
// UART receiver with runtime frame format (5-8 data bits, none/even/odd parity, 1-2 stop bits),
// false-start and break detection, and an RX FIFO with overrun flag and RTS flow control.
module tqvp_uart_rx_fifo #(
  parameter int COUNT_REG_LEN = 13,
  parameter int FIFO_DEPTH    = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rxd,
  output logic                          uart_rts,
  input  logic [COUNT_REG_LEN-1:0]      baud_divider,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          uart_rx_read,
  output logic                          uart_rx_valid,
  output logic [7:0]                    uart_rx_data,
  output logic                          uart_rx_parity_err,
  output logic                          uart_rx_frame_err,
  output logic                          uart_rx_break,
  output logic                          uart_rx_overrun,
  input  logic                          overrun_clear,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2, ST_BREAK_WAIT
  } state_t;

  // Even parity flags an error on XOR=1, odd parity on XOR=0.
  function automatic logic parity_err_calc(input logic [7:0] data, input logic pbit, input logic odd);
    parity_err_calc = (^data) ^ pbit ^ odd;
  endfunction

  state_t                   r_state;
  logic [SYNC_STAGES-1:0]   r_sync;
  logic [COUNT_REG_LEN-1:0] r_cyc;
  logic [2:0]               r_bit_idx;
  logic [7:0]               r_data;
  logic                     r_perr;
  logic                     r_ferr;
  logic                     r_brk;
  logic                     r_all_zero;
  logic [10:0]              r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [LVL_W-1:0]         r_level;
  logic                     r_valid;
  logic                     r_rts;
  logic                     r_overrun;

  logic                     w_rxd_s;
  logic                     w_mid;
  logic                     w_end;
  logic [2:0]               w_last_idx;
  logic                     w_push;
  logic                     w_entry_brk;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_push_ok;
  logic [LVL_W-1:0]         w_level_nxt;

  assign w_rxd_s    = r_sync[SYNC_STAGES-1];
  assign w_mid      = (r_cyc == (baud_divider >> 1));
  assign w_end      = (r_cyc == baud_divider);
  assign w_last_idx = 3'd4 + {1'b0, cfg_data_bits};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rxd};
    end
  end

  // Frame FSM; the bit counter is parked at 0 whenever the line is not being timed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cyc      <= '0;
      r_bit_idx  <= 3'd0;
      r_data     <= 8'd0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_brk      <= 1'b0;
      r_all_zero <= 1'b1;
    end else begin
      r_cyc <= w_end ? '0 : r_cyc + COUNT_REG_LEN'(1);
      case (r_state)
        ST_IDLE: begin
          r_cyc <= '0;
          if (!w_rxd_s) begin
            r_state    <= ST_START;
            r_bit_idx  <= 3'd0;
            r_data     <= 8'd0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_brk      <= 1'b0;
            r_all_zero <= 1'b1;
          end
        end
        ST_START: begin
          if (w_mid && w_rxd_s) begin
            r_state <= ST_IDLE;
            r_cyc   <= '0;
          end else if (w_end) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_mid) begin
            r_data[r_bit_idx] <= w_rxd_s;
            if (w_rxd_s) r_all_zero <= 1'b0;
          end
          if (w_end) begin
            if (r_bit_idx == w_last_idx) begin
              r_state <= cfg_parity[1] ? ST_PARITY : ST_STOP1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          if (w_mid) begin
            r_perr <= parity_err_calc(r_data, w_rxd_s, cfg_parity[0]);
            if (w_rxd_s) r_all_zero <= 1'b0;
          end
          if (w_end) r_state <= ST_STOP1;
        end
        ST_STOP1: begin
          if (w_mid) begin
            r_ferr <= ~w_rxd_s;
            r_brk  <= r_all_zero & ~w_rxd_s;
            if (!cfg_stop2) begin
              r_state <= (r_all_zero && !w_rxd_s) ? ST_BREAK_WAIT : ST_IDLE;
              r_cyc   <= '0;
            end
          end else if (w_end && cfg_stop2) begin
            r_state <= ST_STOP2;
          end
        end
        ST_STOP2: begin
          if (w_mid) begin
            r_state <= r_brk ? ST_BREAK_WAIT : ST_IDLE;
            r_cyc   <= '0;
          end
        end
        ST_BREAK_WAIT: begin
          r_cyc <= '0;
          if (w_rxd_s) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cyc   <= '0;
        end
      endcase
    end
  end

  // Completion strobe: the entry is assembled from the live stop-bit sample.
  always_comb begin
    w_push      = 1'b0;
    w_entry_brk = 1'b0;
    case (r_state)
      ST_STOP1: begin
        w_push      = w_mid & ~cfg_stop2;
        w_entry_brk = r_all_zero & ~w_rxd_s;
      end
      ST_STOP2: begin
        w_push      = w_mid;
        w_entry_brk = r_brk;
      end
      default: begin
        w_push      = 1'b0;
        w_entry_brk = 1'b0;
      end
    endcase
  end

  assign w_pop     = uart_rx_read & (r_level != LVL_W'(0));
  assign w_full    = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_push_ok = w_push & (~w_full | w_pop);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push_ok && !w_pop) begin
      w_level_nxt = r_level + LVL_W'(1);
    end else if (!w_push_ok && w_pop) begin
      w_level_nxt = r_level - LVL_W'(1);
    end else begin
      w_level_nxt = r_level;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 11'd0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_valid   <= 1'b0;
      r_rts     <= 1'b1;
      r_overrun <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= {r_data, r_perr, r_ferr | ~w_rxd_s, w_entry_brk};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_level <= w_level_nxt;
      r_valid <= (w_level_nxt != LVL_W'(0));
      r_rts   <= (w_level_nxt >= LVL_W'(FIFO_DEPTH - 1));
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_push && !w_push_ok) begin
        r_overrun <= 1'b1;
      end else if (overrun_clear) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  assign {uart_rx_data, uart_rx_parity_err, uart_rx_frame_err, uart_rx_break} = r_mem[r_rd_ptr];
  assign uart_rx_valid   = r_valid;
  assign uart_rts        = r_rts;
  assign uart_rx_overrun = r_overrun;
  assign fifo_level      = r_level;

endmodule
